dpu_pipe: RTL

Parametrised, clocked successor to the graphics datapath unit. Holds a DATA_W x REG_DEPTH register file, executes one ALU/load/emit operation per accepted command through a two-stage issue/execute pipeline, and updates condition codes. It pushes pixel words {X, Y, colour} into a 2-entry output buffer drained by the video stage over a valid/ready handshake. It sits between the control sequencer (command source) and the video output block.

---
 rtl/dpu_pipe_if.sv | 28 ++
 rtl/dpu_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dpu_pipe_if.sv
// Command and pixel channels of dpu_pipe: issue handshake from the sequencer,
// condition codes, and the valid/ready pixel stream to the video stage.
interface dpu_pipe_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
);
    logic                  op_valid;
    logic                  op_ready;
    logic [3:0]            op_code;
    logic [AW-1:0]         a_sel;
    logic [AW-1:0]         b_sel;
    logic [AW-1:0]         r_sel;
    logic [DATA_W-1:0]     mem_data;
    logic [3:0]            cc;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [3*DATA_W-1:0]   pix_data;

    modport master (
        output op_valid, op_code, a_sel, b_sel, r_sel, mem_data, pix_ready,
        input  op_ready, cc, pix_valid, pix_data
    );

    modport slave (
        input  op_valid, op_code, a_sel, b_sel, r_sel, mem_data, pix_ready,
        output op_ready, cc, pix_valid, pix_data
    );
endinterface

// File: rtl/dpu_pipe.sv
// Two-stage (issue/execute) graphics datapath with register file, flags and a
// 2-entry pixel buffer. Define DPU_FWD_EN to forward execute results to issue.
module dpu_pipe #(
    parameter int DATA_W    = 8,
    parameter int REG_DEPTH = 16,
    parameter int X_REG     = 9,
    parameter int Y_REG     = 10,
    parameter int C_REG     = 11,
    parameter int ONE_REG   = 12
) (
    input  logic      clk,
    input  logic      rst,
    dpu_pipe_if.slave bus
);
    localparam int AW  = $clog2(REG_DEPTH);
    localparam int PW  = 3 * DATA_W;
    localparam int MSB = DATA_W - 1;

`ifdef DPU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_LOAD = 4'd8,
        OP_EMIT = 4'd9,
        OP_MOV  = 4'd10
    } op_e;

    logic [DATA_W-1:0] regs_q [REG_DEPTH];
    logic [DATA_W-1:0] regs_d [REG_DEPTH];
    logic [DATA_W-1:0] rf_view [REG_DEPTH];
    logic [3:0]        cc_q, cc_d;

    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_op_q, ex_op_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;
    logic [AW-1:0]     ex_r_q, ex_r_d;
    logic [DATA_W-1:0] ex_mem_q, ex_mem_d;
    logic [PW-1:0]     ex_pix_q, ex_pix_d;

    logic [PW-1:0]     fifo_q [2];
    logic [PW-1:0]     fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [DATA_W:0]   add_full;
    logic [DATA_W-1:0] sub_res;
    logic [DATA_W-1:0] ex_res;
    logic              c_flag, v_flag;
    logic              ex_wr, ex_cc_upd, ex_emit;
    logic              reads_a, reads_b, reads_pix;
    logic              hazard, buf_busy, accept, push, pop;

    // ---------------- execute stage ----------------
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        add_full  = {1'b0, ex_a_q} + {1'b0, ex_b_q};
        sub_res   = ex_a_q - ex_b_q;
        ex_res    = '0;
        c_flag    = 1'b0;
        v_flag    = 1'b0;
        ex_wr     = 1'b0;
        ex_cc_upd = 1'b0;
        ex_emit   = 1'b0;
        case (ex_op_q)
            OP_ADD: begin
                ex_res    = add_full[MSB:0];
                c_flag    = add_full[DATA_W];
                v_flag    = (ex_a_q[MSB] == ex_b_q[MSB]) && (add_full[MSB] != ex_a_q[MSB]);
                ex_wr     = 1'b1;
                ex_cc_upd = 1'b1;
            end
            OP_SUB: begin
                ex_res    = sub_res;
                c_flag    = ex_a_q < ex_b_q;
                v_flag    = (ex_a_q[MSB] != ex_b_q[MSB]) && (sub_res[MSB] != ex_a_q[MSB]);
                ex_wr     = 1'b1;
                ex_cc_upd = 1'b1;
            end
            OP_AND:  begin ex_res = ex_a_q & ex_b_q; ex_wr = 1'b1; ex_cc_upd = 1'b1; end
            OP_OR:   begin ex_res = ex_a_q | ex_b_q; ex_wr = 1'b1; ex_cc_upd = 1'b1; end
            OP_XOR:  begin ex_res = ex_a_q ^ ex_b_q; ex_wr = 1'b1; ex_cc_upd = 1'b1; end
            OP_NOT:  begin ex_res = ~ex_a_q;         ex_wr = 1'b1; ex_cc_upd = 1'b1; end
            OP_SHL: begin
                ex_res    = {ex_a_q[MSB-1:0], 1'b0};
                c_flag    = ex_a_q[MSB];
                ex_wr     = 1'b1;
                ex_cc_upd = 1'b1;
            end
            OP_SHR: begin
                ex_res    = {1'b0, ex_a_q[MSB:1]};
                c_flag    = ex_a_q[0];
                ex_wr     = 1'b1;
                ex_cc_upd = 1'b1;
            end
            OP_LOAD: begin ex_res = ex_mem_q; ex_wr = 1'b1; end
            OP_EMIT: ex_emit = 1'b1;
            OP_MOV:  begin ex_res = ex_a_q; ex_wr = 1'b1; ex_cc_upd = 1'b1; end
            default: ;
        endcase
        if (!ex_valid_q) begin
            ex_wr     = 1'b0;
            ex_cc_upd = 1'b0;
            ex_emit   = 1'b0;
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (ex_wr) regs_d[ex_r_q] = ex_res;
        cc_d = ex_cc_upd ? {ex_res[MSB], ex_res == '0, c_flag, v_flag} : cc_q;
    end

    // ---------------- issue stage ----------------
    // Register file as seen by issue: the execute result overrides its target when forwarding.
    always_comb begin
        for (int i = 0; i < REG_DEPTH; i++) begin
            rf_view[i] = (FWD && ex_wr && ex_r_q == AW'(i)) ? ex_res : regs_q[i];
        end
    end

    always_comb begin
        reads_a   = 1'b0;
        reads_b   = 1'b0;
        reads_pix = 1'b0;
        case (bus.op_code)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin reads_a = 1'b1; reads_b = 1'b1; end
            OP_NOT, OP_SHL, OP_SHR, OP_MOV:        reads_a = 1'b1;
            OP_EMIT:                               reads_pix = 1'b1;
            default: ;
        endcase
        hazard = !FWD && bus.op_valid && ex_wr &&
                 ((reads_a && ex_r_q == bus.a_sel) ||
                  (reads_b && ex_r_q == bus.b_sel) ||
                  (reads_pix && (ex_r_q == AW'(X_REG) || ex_r_q == AW'(Y_REG) ||
                                 ex_r_q == AW'(C_REG))));
        // The execute-stage EMIT already owns one buffer slot.
        buf_busy     = (cnt_q == 2'd2) || (cnt_q == 2'd1 && ex_emit);
        bus.op_ready = !buf_busy && !hazard;
        accept       = bus.op_valid && bus.op_ready;

        ex_valid_d = accept;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_r_d     = ex_r_q;
        ex_mem_d   = ex_mem_q;
        ex_pix_d   = ex_pix_q;
        if (accept) begin
            ex_op_d  = bus.op_code;
            ex_a_d   = rf_view[bus.a_sel];
            ex_b_d   = rf_view[bus.b_sel];
            ex_r_d   = bus.r_sel;
            ex_mem_d = bus.mem_data;
            ex_pix_d = {rf_view[X_REG], rf_view[Y_REG], rf_view[C_REG]};
        end
    end

    // ---------------- pixel buffer ----------------
    always_comb begin
        push     = ex_emit;
        pop      = bus.pix_valid && bus.pix_ready;
        fifo_d   = fifo_q;
        if (push) fifo_d[wr_ptr_q] = ex_pix_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (!push && pop) cnt_d = cnt_q - 2'd1;
    end

    assign bus.pix_valid = cnt_q != 2'd0;
    assign bus.pix_data  = fifo_q[rd_ptr_q];
    assign bus.cc        = cc_q;

    // NOTE: state updates use <= so every flop samples pre-edge values; the register file
    // and buffer storage are reset explicitly because ONE_REG and pix_data have reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= (i == ONE_REG) ? DATA_W'(1) : '0;
            end
            cc_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_r_q     <= '0;
            ex_mem_q   <= '0;
            ex_pix_q   <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            regs_q     <= regs_d;
            cc_q       <= cc_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_r_q     <= ex_r_d;
            ex_mem_q   <= ex_mem_d;
            ex_pix_q   <= ex_pix_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end
endmodule
